// File: rtl/rx_block_lock.sv
// ---------------------------------------------------------------------------
// rx_block_lock
//   64b/66b receive block-lock state machine. Watches the 2-bit sync header
//   delivered by the transceiver gearbox and steers the gearbox with one-bit
//   slip requests until 66-bit block alignment is found, then supervises the
//   lock with a windowed invalid-header budget.
//
// Parameters
//   SH_CNT_MAX   : headers per test window
//   SH_INVLD_MAX : invalid headers in one window that drop an acquired lock
//   SLIP_WAIT    : cycles after a slip during which headers are ignored
//
// Ports
//   xver_rx_clk    in   transceiver RX user clock (rising edge)
//   i_reset_n      in   asynchronous active-low reset
//   i_header[1:0]  in   sync header from the gearbox
//   i_header_valid in   i_header carries a header this cycle
//   o_gearbox_slip out  single-cycle slip request to the gearbox
//   o_block_lock   out  block alignment acquired
//   o_slip_count   out  saturating count of slips since reset
// ---------------------------------------------------------------------------
module rx_block_lock #(
  parameter int unsigned SH_CNT_MAX   = 64,
  parameter int unsigned SH_INVLD_MAX = 16,
  parameter int unsigned SLIP_WAIT    = 32
) (
  input  logic       xver_rx_clk,
  input  logic       i_reset_n,
  input  logic [1:0] i_header,
  input  logic       i_header_valid,
  output logic       o_gearbox_slip,
  output logic       o_block_lock,
  output logic [7:0] o_slip_count
);

  localparam int unsigned CNT_W  = $clog2(SH_CNT_MAX + 1);
  localparam int unsigned INV_W  = $clog2(SH_INVLD_MAX + 1);
  localparam int unsigned WAIT_W = $clog2(SLIP_WAIT + 1);

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(SH_CNT_MAX);
  localparam logic [INV_W-1:0]  INV_LAST  = INV_W'(SH_INVLD_MAX);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SLIP_WAIT - 1);

  typedef enum logic [1:0] {
    ST_RESET_CNT = 2'd0,
    ST_TEST_SH   = 2'd1,
    ST_SLIP      = 2'd2,
    ST_SLIP_WAIT = 2'd3
  } state_e;

  state_e              state_q,     state_d;
  logic [CNT_W-1:0]    sh_cnt_q,    sh_cnt_d;
  logic [INV_W-1:0]    invld_cnt_q, invld_cnt_d;
  logic [WAIT_W-1:0]   wait_cnt_q,  wait_cnt_d;
  logic                lock_q,      lock_d;
  logic                slip_q,      slip_d;
  logic [7:0]          slip_cnt_q,  slip_cnt_d;
  logic [1:0]          rst_sync_q;

  logic                run;
  logic                hdr_ok;
  logic [CNT_W-1:0]    sh_cnt_inc;
  logic [INV_W-1:0]    invld_cnt_inc;

  // Assertion clears everything at once; release is held off for two edges
  // so the state machine never starts on a partially released reset.
  always_ff @(posedge xver_rx_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rst_sync_q <= '0;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign run           = rst_sync_q[1];
  assign hdr_ok        = i_header[1] ^ i_header[0];
  assign sh_cnt_inc    = sh_cnt_q + 1'b1;
  assign invld_cnt_inc = invld_cnt_q + INV_W'(!hdr_ok);

  always_comb begin
    state_d     = state_q;
    sh_cnt_d    = sh_cnt_q;
    invld_cnt_d = invld_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    lock_d      = lock_q;
    slip_d      = 1'b0;
    slip_cnt_d  = slip_cnt_q;

    if (run) begin
      unique case (state_q)
        ST_RESET_CNT: begin
          sh_cnt_d    = '0;
          invld_cnt_d = '0;
          state_d     = ST_TEST_SH;
        end

        ST_TEST_SH: begin
          if (i_header_valid) begin
            if (!lock_q) begin
              // Hunting: any invalid header (even the last of a window)
              // means the alignment is wrong, so slip immediately.
              if (!hdr_ok) begin
                state_d = ST_SLIP;
                slip_d  = 1'b1;
              end else if (sh_cnt_inc == CNT_LAST) begin
                lock_d  = 1'b1;
                state_d = ST_RESET_CNT;
              end else begin
                sh_cnt_d = sh_cnt_inc;
              end
            end else begin
              // Locked: the invalid budget is checked before the window end
              // so a window closing on its last allowed error still drops lock.
              if (invld_cnt_inc == INV_LAST) begin
                lock_d  = 1'b0;
                state_d = ST_SLIP;
                slip_d  = 1'b1;
              end else if (sh_cnt_inc == CNT_LAST) begin
                state_d = ST_RESET_CNT;
              end else begin
                sh_cnt_d    = sh_cnt_inc;
                invld_cnt_d = invld_cnt_inc;
              end
            end
          end
        end

        ST_SLIP: begin
          wait_cnt_d = '0;
          state_d    = ST_SLIP_WAIT;
        end

        ST_SLIP_WAIT: begin
          if (wait_cnt_q == WAIT_LAST) begin
            state_d = ST_RESET_CNT;
          end else begin
            wait_cnt_d = wait_cnt_q + 1'b1;
          end
        end

        default: state_d = ST_RESET_CNT;
      endcase
    end

    // The slip pulse and counter are registered together with the entry into
    // SLIP, so the pulse is exactly the SLIP-state cycle.
    if (slip_d && (slip_cnt_q != 8'hFF)) begin
      slip_cnt_d = slip_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge xver_rx_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= ST_RESET_CNT;
      sh_cnt_q    <= '0;
      invld_cnt_q <= '0;
      wait_cnt_q  <= '0;
      lock_q      <= 1'b0;
      slip_q      <= 1'b0;
      slip_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      sh_cnt_q    <= sh_cnt_d;
      invld_cnt_q <= invld_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      lock_q      <= lock_d;
      slip_q      <= slip_d;
      slip_cnt_q  <= slip_cnt_d;
    end
  end

  assign o_gearbox_slip = slip_q;
  assign o_block_lock   = lock_q;
  assign o_slip_count   = slip_cnt_q;

endmodule

// File: doc/rx_block_lock.md
RX_BLOCK_LOCK -- requirements
Module: rx_block_lock

Interface
REQ-001 Parameter SH_CNT_MAX, default 64: number of valid-header events in one test window.
REQ-002 Parameter SH_INVLD_MAX, default 16: number of invalid headers within one window that causes loss of lock while locked.
REQ-003 Parameter SLIP_WAIT, default 32: number of clock cycles after a slip pulse during which headers are ignored (gearbox settle time).
REQ-004 Port xver_rx_clk, input, 1 bit: the block's single clock, the transceiver RX user clock; all logic is on its rising edge.
REQ-005 Port i_reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port i_header, input, 2 bits: 64b/66b sync header from the transceiver gearbox.
REQ-007 Port i_header_valid, input, 1 bit: i_header is valid this cycle (one valid event per 66-bit block, with gaps).
REQ-008 Port o_gearbox_slip, output, 1 bit: single-cycle request to the transceiver gearbox to slip one bit.
REQ-009 Port o_block_lock, output, 1 bit: high when 66-bit block alignment is acquired.
REQ-010 Port o_slip_count, output, 8 bits: saturating count of slips issued since reset.

Function
REQ-011 A header is valid when it is 2'b01 or 2'b10; 2'b00 and 2'b11 are invalid.
REQ-012 Headers are evaluated only on cycles with i_header_valid=1; cycles with i_header_valid=0 change no counter or state.
REQ-013 The state machine has four states: RESET_CNT, TEST_SH, SLIP, SLIP_WAIT.
REQ-014 Counters: sh_cnt counts valid-header events up to SH_CNT_MAX; sh_invld_cnt counts invalid headers up to SH_INVLD_MAX.
REQ-015 RESET_CNT: clears sh_cnt and sh_invld_cnt, then moves to TEST_SH on the next cycle; a header presented in RESET_CNT is ignored.
REQ-016 TEST_SH, unlocked: an invalid header moves to SLIP on the next cycle.
REQ-017 TEST_SH, unlocked: when the SH_CNT_MAX-th consecutive valid header is evaluated, o_block_lock rises on the next cycle and the state moves to RESET_CNT.
REQ-018 TEST_SH, locked: when the SH_CNT_MAX-th header is evaluated with sh_invld_cnt < SH_INVLD_MAX (including that header), the state moves to RESET_CNT and lock is retained.
REQ-019 TEST_SH, locked: when sh_invld_cnt reaches SH_INVLD_MAX, o_block_lock falls on the next cycle and the state moves to SLIP, even if this is also the SH_CNT_MAX-th header.
REQ-020 Priority when unlocked: if the SH_CNT_MAX-th header is invalid, the state moves to SLIP and lock is not acquired.
REQ-021 SLIP: o_gearbox_slip=1 for exactly one cycle; o_slip_count increments, saturating at 255; the state moves to SLIP_WAIT.
REQ-022 SLIP_WAIT: the wait counter runs for SLIP_WAIT cycles regardless of i_header_valid, all headers are ignored, and the state then moves to RESET_CNT.
REQ-023 o_gearbox_slip is never high on two consecutive cycles, and is never high outside the SLIP state.
REQ-024 All outputs are registered, with no combinational path from any input to any output.
REQ-025 Latency: the response (lock change or slip) is visible on the cycle after the triggering header is evaluated.

Reset
REQ-026 While i_reset_n=0: o_gearbox_slip=0, o_block_lock=0, o_slip_count=0, all counters cleared, and the state is RESET_CNT; outputs clear immediately on assertion, without waiting for a clock edge.
REQ-027 Reset asserted mid-operation (any state, including SLIP or SLIP_WAIT) aborts that operation; no slip pulse is produced after release.
REQ-028 Deassertion is synchronised to xver_rx_clk inside the block; the first header is evaluated no earlier than the second edge after release.

Verification
REQ-029 64 valid headers alternating 01/10, with i_header_valid high every other cycle -> o_block_lock=1 on the cycle after the 64th; o_gearbox_slip stays 0 throughout; o_slip_count=0.
REQ-030 Unlocked, 10th header = 2'b00 -> one o_gearbox_slip pulse one cycle later; o_slip_count=1; headers during the following 32 cycles are ignored (no further slip, even if invalid).
REQ-031 Locked, 15 invalid headers within a 64-header window -> lock is retained; the next window with 16 invalid headers -> o_block_lock=0 and one slip pulse on the cycle after the 16th.
REQ-032 64 valid headers spread over 200 cycles with random valid gaps -> lock on the cycle after the 64th valid; the 63rd valid header alone does not produce lock.
REQ-033 i_reset_n pulled low during SLIP_WAIT -> all outputs 0 immediately; after release, 64 fresh valid headers are required for lock; no slip pulse appears.
REQ-034 300 forced slips (a permanently invalid header) -> o_slip_count saturates at 255 and does not wrap; every slip pulse is separated by at least 33 cycles.
